// File: rtl/nios_timer_pkg.sv
// nios_timer_pkg: register offsets, CONTROL/STATUS bit positions and per-channel state
package nios_timer_pkg;
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;
  localparam int ST_TO     = 0;
  localparam int ST_RUN    = 1;
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_PRESC = 8;
  typedef struct packed {
    logic        run;
    logic        to;
    logic        ito;
    logic        cont;
    logic [7:0]  presc;
    logic [31:0] period;
    logic [31:0] snap;
  } chan_state_t;
endpackage

// File: rtl/nios_timer_channel.sv
// nios_timer_channel: one down-counting timer channel; prescaler built only with TIMER_PRESCALER_EN
module nios_timer_channel
  import nios_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [1:0]  reg_i,
  input  logic [31:0] wdata_i,
  output chan_state_t st_o
);
  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);
  logic run_q, run_d, to_q, to_d, ito_q, cont_q, zero_q, rl_q;
  logic [CNT_W-1:0] period_q, cnt_q, cnt_d, snap_q;
  logic wr_st, wr_ctl, wr_per, wr_snap, start, stop, zero, tick;
  logic [7:0] presc;
`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc_q, pcnt_q;
  assign tick  = pcnt_q == presc_q;
  assign presc = presc_q;
  // prescaler divides the clock by PRESC+1; held at 0 while stopped, restarted on START and force reload
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= wr_ctl ? wdata_i[CTL_PRESC +: 8] : presc_q;
      pcnt_q  <= (start || rl_q || !run_q || tick) ? '0 : pcnt_q + 8'd1;
    end
`else
  assign tick  = 1'b1;
  assign presc = '0;
`endif
  // write decode plus counter, RUN and TO next state; START beats STOP, force reload and one-shot end
  always_comb begin
    wr_st   = we_i && reg_i == REG_STATUS;
    wr_ctl  = we_i && reg_i == REG_CONTROL;
    wr_per  = we_i && reg_i == REG_PERIOD;
    wr_snap = we_i && reg_i == REG_SNAP;
    start   = wr_ctl && wdata_i[CTL_START];
    stop    = wr_ctl && wdata_i[CTL_STOP];
    zero    = cnt_q == '0;
    run_d   = start ? 1'b1 : (rl_q || stop || (run_q && tick && zero && !cont_q)) ? 1'b0 : run_q;
    cnt_d   = rl_q ? period_q : (run_q && tick) ? (zero ? period_q : cnt_q - CNT_W'(1)) : cnt_q;
    to_d    = !wr_st && (to_q || (zero && !zero_q));
  end
  // channel registers; PERIOD write arms a reload that lands one cycle later
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      zero_q   <= RST_P == '0;
      rl_q     <= 1'b0;
      period_q <= RST_P;
      cnt_q    <= RST_P;
      snap_q   <= '0;
    end else begin
      run_q    <= run_d;
      to_q     <= to_d;
      ito_q    <= wr_ctl ? wdata_i[CTL_ITO] : ito_q;
      cont_q   <= wr_ctl ? wdata_i[CTL_CONT] : cont_q;
      zero_q   <= zero;
      rl_q     <= wr_per;
      period_q <= wr_per ? wdata_i[CNT_W-1:0] : period_q;
      cnt_q    <= cnt_d;
      snap_q   <= wr_snap ? cnt_q : snap_q;
    end
  assign st_o = '{run: run_q, to: to_q, ito: ito_q, cont: cont_q, presc: presc,
                  period: 32'(period_q), snap: 32'(snap_q)};
endmodule

// File: rtl/nios_multi_timer.sv
// nios_multi_timer: NUM_CH Avalon-MM timer channels with registered read mux and OR'd irq; TIMER_PRESCALER_EN enables per-channel prescalers
module nios_multi_timer
  import nios_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999,
  parameter int AW         = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);
  chan_state_t st [NUM_CH];
  logic [AW-1:0] ch;
  logic [1:0] rsel;
  logic [31:0] readdata_d, readdata_q;
  assign ch   = address >> 2;
  assign rsel = address[1:0];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nios_timer_channel #(.CNT_W(CNT_W), .RST_PERIOD(RST_PERIOD)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we_i    (chipselect && !write_n && int'(ch) == i),
      .reg_i   (rsel),
      .wdata_i (writedata),
      .st_o    (st[i])
    );
    assign irq_vec[i] = st[i].to && st[i].ito;
  end
  // read mux; channels beyond NUM_CH match nothing and read 0
  always_comb begin
    readdata_d = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (int'(ch) == n)
        readdata_d = rsel == REG_STATUS  ? 32'({st[n].run, st[n].to}) :
                     rsel == REG_CONTROL ? {16'd0, st[n].presc, 6'd0, st[n].cont, st[n].ito} :
                     rsel == REG_PERIOD  ? st[n].period : st[n].snap;
  end
  // one-cycle registered read data
  always_ff @(posedge clk or posedge reset)
    if (reset) readdata_q <= '0;
    else readdata_q <= readdata_d;
  assign readdata = readdata_q;
  assign irq      = |irq_vec;
endmodule

// File: doc/nios_multi_timer.md
NIOS_MULTI_TIMER -- requirements
Module: nios_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning counter/period width in bits (8..32).
REQ-003 SHALL have parameter RST_PERIOD, default 49999, meaning period and counter reset value for every channel.
REQ-004 SHALL have parameter AW, default $clog2(NUM_CH)+2, meaning address width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; everything is sampled on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port address, input, AW, meaning {channel, reg[1:0]}.
REQ-008 SHALL have port chipselect, input, 1, meaning slave select.
REQ-009 SHALL have port write_n, input, 1, meaning active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, meaning write data.
REQ-011 SHALL have port readdata, output, 32, meaning registered read data.
REQ-012 SHALL have port irq_vec, output, NUM_CH, meaning per-channel interrupt.
REQ-013 SHALL have port irq, output, 1, meaning OR of irq_vec.

Function
REQ-014 Register map per channel SHALL be: 0 STATUS {RUN[1], TO[0]}; 1 CONTROL {PRESC[15:8], STOP[3], START[2], CONT[1], ITO[0]}; 2 PERIOD[CNT_W-1:0]; 3 SNAP.
REQ-015 readdata SHALL update every cycle with the addressed register (zero-extended), giving a 1-cycle read latency; unused bits read 0. Out-of-range channels read 0 and ignore writes.
REQ-016 A write to STATUS with any data SHALL clear TO; TO clear takes priority over a same-cycle timeout.
REQ-017 A write to CONTROL SHALL store ITO, CONT and PRESC; START=1 SHALL set RUN next cycle; STOP=1 SHALL clear RUN; START=STOP=1 SHALL set RUN (start wins).
REQ-018 A write to PERIOD SHALL load PERIOD, then, on the next cycle, reload the counter from the new PERIOD and clear RUN (force reload).
REQ-019 A write to SNAP SHALL copy the live counter into SNAP; a read of SNAP SHALL return the captured value.
REQ-020 While RUN=1 and a tick occurs, the counter SHALL decrement by 1; at 0 it SHALL reload PERIOD on the next tick instead of decrementing.
REQ-021 A timeout event SHALL be the rising edge of (counter==0); it SHALL set TO the following cycle.
REQ-022 At counter==0 with CONT=0, RUN SHALL clear (one-shot); with CONT=1, RUN SHALL remain set.
REQ-023 irq_vec[i] SHALL equal TO[i] AND ITO[i], combinationally from registers.
REQ-024 PERIOD=0 SHALL produce a single timeout and hold the counter at 0 with no further events.

Reset
REQ-025 Reset SHALL clear RUN, TO, CONTROL, SNAP, readdata and prescaler counts, and SHALL set PERIOD and counter to RST_PERIOD[CNT_W-1:0]; irq and irq_vec SHALL be 0.
REQ-026 Reset asserted mid-count SHALL take effect immediately (asynchronously), and counting SHALL resume only after a new START.

Configuration
REQ-027 With TIMER_PRESCALER_EN defined, a tick SHALL occur once every PRESC+1 clocks per channel; the prescaler SHALL restart at START and at force reload.
REQ-028 Without TIMER_PRESCALER_EN, tick SHALL be 1 every clock, PRESC SHALL read 0, and its writes SHALL be ignored.

Structure
REQ-029 Package nios_timer_pkg SHALL hold register offsets, CONTROL/STATUS bit positions and the channel-state typedef.
REQ-030 Sub-module nios_timer_channel SHALL implement one channel (counter, prescaler, RUN/TO, SNAP); the top SHALL hold NUM_CH instances, address decode, read mux and irq OR.

Verification
REQ-031 Reset, then read ch0 PERIOD -> 49999; read STATUS -> 0; irq=0.
REQ-032 ch1 PERIOD=9, CONTROL=0x7 (CONT, START, ITO) -> TO/irq_vec[1] set every 10 clocks; write STATUS -> irq clears within 1 cycle.
REQ-033 ch2 PERIOD=4, CONTROL=0x4 (one-shot) -> exactly one TO; RUN=0 after the timeout; no second event in 50 clocks.
REQ-034 ch0 running at PERIOD=100, write PERIOD=20 mid-count -> RUN=0 and counter=20 after 2 cycles; SNAP write then read -> 20.
REQ-035 Timeout on the same cycle as a STATUS write -> TO remains 0; CONTROL=0xC -> RUN=1.
REQ-036 TIMER_PRESCALER_EN, PRESC=3, PERIOD=2, CONT -> timeout every 12 clocks; without the macro, every 3 clocks.
